// File: rtl/hack_vga_pixel.sv
// hack_vga_pixel
//   Pixel generation stage behind the VGA sync generator. Places the
//   512x256 monochrome Hack screen inside the 640x480 active area,
//   fetches one 16-bit screen word every 16 pixels and serializes it
//   (bit 0 = leftmost pixel) into 12-bit RGB. Sync signals are delayed
//   to stay aligned with the colour output (3-cycle latency).
//
// Ports
//   pixel_clk            pixel clock
//   reset_n              asynchronous active-low reset
//   in_hsync, in_vsync   syncs from the sync generator
//   in_video_on          active-area flag from the sync generator
//   x_addr, y_addr       display coordinates (valid when in_video_on)
//   ram_addr, ram_rd     screen RAM word address / read strobe
//   ram_rdata            screen RAM data, one cycle after ram_addr/ram_rd
//   vga_hsync, vga_vsync syncs delayed by 3 cycles
//   vga_r, vga_g, vga_b  pixel colour
module hack_vga_pixel #(
    parameter int          X_OFF   = 64,
    parameter int          Y_OFF   = 112,
    parameter logic [11:0] PIX_ON  = 12'h000,
    parameter logic [11:0] PIX_OFF = 12'hFFF,
    parameter logic [11:0] BORDER  = 12'h222
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_video_on,
    input  logic [9:0]  x_addr,
    input  logic [9:0]  y_addr,
    output logic [12:0] ram_addr,
    output logic        ram_rd,
    input  logic [15:0] ram_rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam logic signed [11:0] X_OFF_S = 12'(X_OFF);
    localparam logic signed [11:0] Y_OFF_S = 12'(Y_OFF);

    function automatic logic [11:0] colour_sel(input logic vld, input logic win,
                                               input logic pix);
        if (!vld)
            return 12'h000;
        if (!win)
            return BORDER;
        return pix ? PIX_ON : PIX_OFF;
    endfunction

    // ---- stage 0: window test on the raw inputs ----
    logic signed [11:0] dx_p0;
    logic signed [11:0] dy_p0;
    logic               win_p0;
    logic               ws_p0;
    logic [8:0]         hx_p0;
    logic [7:0]         hy_p0;

    assign dx_p0  = $signed({2'b00, x_addr}) - X_OFF_S;
    assign dy_p0  = $signed({2'b00, y_addr}) - Y_OFF_S;
    assign win_p0 = in_video_on
                    && (dx_p0 >= 12'sd0) && (dx_p0 < 12'sd512)
                    && (dy_p0 >= 12'sd0) && (dy_p0 < 12'sd256);
    assign hx_p0  = dx_p0[8:0];
    assign hy_p0  = dy_p0[7:0];
    assign ws_p0  = win_p0 && (hx_p0[3:0] == 4'd0);

    // ---- stage 1: word fetch ----
    logic vld_p1, win_p1, ws_p1, hs_p1, vs_p1;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            win_p1   <= 1'b0;
            ws_p1    <= 1'b0;
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b0;
            ram_addr <= 13'd0;
            ram_rd   <= 1'b0;
        end else begin
            vld_p1 <= in_video_on;
            win_p1 <= win_p0;
            ws_p1  <= ws_p0;
            hs_p1  <= in_hsync;
            vs_p1  <= in_vsync;
            ram_rd <= ws_p0;
            if (ws_p0)
                ram_addr <= {hy_p0, hx_p0[8:4]};
        end
    end

    // ---- stage 2: RAM data arrives, serialize ----
    logic        vld_p2, win_p2, ws_p2, hs_p2, vs_p2;
    logic [15:0] shift_reg;
    logic        pix_p2;

    // A word start always takes its pixel straight from the RAM, so the
    // shifter never has to be primed and stale bits never reach the screen.
    assign pix_p2 = ws_p2 ? ram_rdata[0] : shift_reg[0];

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2    <= 1'b0;
            win_p2    <= 1'b0;
            ws_p2     <= 1'b0;
            hs_p2     <= 1'b0;
            vs_p2     <= 1'b0;
            shift_reg <= 16'd0;
        end else begin
            vld_p2 <= vld_p1;
            win_p2 <= win_p1;
            ws_p2  <= ws_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            if (win_p2)
                shift_reg <= ws_p2 ? {1'b0, ram_rdata[15:1]} : {1'b0, shift_reg[15:1]};
        end
    end

    // ---- stage 3: colour select, registered outputs ----
    logic [11:0] rgb_p3;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_p3    <= 12'h000;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
        end else begin
            rgb_p3    <= colour_sel(vld_p2, win_p2, pix_p2);
            vga_hsync <= hs_p2;
            vga_vsync <= vs_p2;
        end
    end

    assign vga_r = rgb_p3[11:8];
    assign vga_g = rgb_p3[7:4];
    assign vga_b = rgb_p3[3:0];

endmodule

// File: tb/tb_hack_vga_pixel.sv
// tb_hack_vga_pixel
//   Directed bench for hack_vga_pixel: reset, single word fetch, maximum
//   address, border/blank, partial frame sweep and mid-line reset.
//   A screen RAM model answers reads with one cycle of latency.
module tb_hack_vga_pixel;

    localparam logic [11:0] C_ON     = 12'h000;
    localparam logic [11:0] C_OFF    = 12'hFFF;
    localparam logic [11:0] C_BORDER = 12'h222;

    logic        pixel_clk;
    logic        reset_n;
    logic        in_hsync, in_vsync, in_video_on;
    logic [9:0]  x_addr, y_addr;
    logic [12:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_rdata;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;

    hack_vga_pixel dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .in_video_on (in_video_on),
        .x_addr      (x_addr),
        .y_addr      (y_addr),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_rdata   (ram_rdata),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic [15:0] mem [0:8191];
    always @(posedge pixel_clk) ram_rdata <= mem[ram_addr];

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        rd;
        logic [12:0] addr;
        logic        chk;
        logic [9:0]  x;
    } ent_t;

    ent_t        hist [3];
    logic [11:0] line_rgb [0:1023];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_cnt  = 0;
    logic [12:0] last_addr = 13'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t blank_ent();
        ent_t e;
        e   = '0;
        e.x = 10'd1023;
        return e;
    endfunction

    // Direct-address model: pixel (hx,hy) is bit hx%16 of word hy*32+hx/16.
    function automatic ent_t model(input logic h, input logic v, input logic vo,
                                   input logic [9:0] xx, input logic [9:0] yy,
                                   input logic ck);
        ent_t        e;
        int          hx, hy;
        logic        w;
        logic [15:0] word;
        e    = '0;
        hx   = int'(xx) - 64;
        hy   = int'(yy) - 112;
        w    = vo && hx >= 0 && hx < 512 && hy >= 0 && hy < 256;
        e.hs = h;
        e.vs = v;
        e.chk = ck;
        e.x  = xx;
        if (!vo)
            e.rgb = 12'h000;
        else if (!w)
            e.rgb = C_BORDER;
        else begin
            word  = mem[hy * 32 + hx / 16];
            e.rgb = word[hx % 16] ? C_ON : C_OFF;
        end
        e.rd = w && (hx % 16 == 0);
        if (w)
            e.addr = 13'(hy * 32 + hx / 16);
        return e;
    endfunction

    task automatic drive(input logic rn, input logic h, input logic v, input logic vo,
                         input logic [9:0] xx, input logic [9:0] yy, input logic ck);
        logic [11:0] rgb;
        @(negedge pixel_clk);
        rgb = {vga_r, vga_g, vga_b};
        check("hsync", {31'd0, vga_hsync}, {31'd0, hist[2].hs});
        check("vsync", {31'd0, vga_vsync}, {31'd0, hist[2].vs});
        if (hist[2].chk)
            check("rgb", {20'd0, rgb}, {20'd0, hist[2].rgb});
        line_rgb[hist[2].x] = rgb;
        check("ram_rd", {31'd0, ram_rd}, {31'd0, hist[0].rd});
        if (hist[0].rd && ram_rd)
            check("ram_addr", {19'd0, ram_addr}, {19'd0, hist[0].addr});
        if (ram_rd) begin
            rd_cnt++;
            last_addr = ram_addr;
        end
        if (!rn && reset_n) begin
            reset_n = 1'b0;
            #1;
            check("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
            check("rst_sync", {30'd0, vga_hsync, vga_vsync}, 32'd0);
            check("rst_rd", {31'd0, ram_rd}, 32'd0);
            for (int i = 0; i < 3; i++) hist[i] = blank_ent();
        end
        reset_n = rn;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = rn ? model(h, v, vo, xx, yy, ck) : blank_ent();
        in_hsync    = h;
        in_vsync    = v;
        in_video_on = vo;
        x_addr      = xx;
        y_addr      = yy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 10'd1023, 10'd1023, 1'b1);
    endtask

    task automatic clear_line();
        for (int i = 0; i < 1024; i++) line_rgb[i] = 12'hBAD;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 16'(a);
        mem[0]    = 16'h0001;
        mem[8191] = 16'h8000;
        for (int i = 0; i < 3; i++) hist[i] = blank_ent();
        in_hsync = 0; in_vsync = 0; in_video_on = 0; x_addr = 0; y_addr = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;

        // reset held with random inputs, then first pixel outside the window
        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                  10'($urandom), 10'($urandom), 1'b1);
        clear_line();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1);
        idle(4);
        check("x0_border", {20'd0, line_rgb[0]}, {20'd0, C_BORDER});

        // first word of the screen, word 0 = 16'h0001
        clear_line();
        for (int x = 60; x <= 90; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd112, 1'b1);
        idle(4);
        check("x63_border", {20'd0, line_rgb[63]}, {20'd0, C_BORDER});
        check("x64_on",     {20'd0, line_rgb[64]}, {20'd0, C_ON});
        check("x65_off",    {20'd0, line_rgb[65]}, {20'd0, C_OFF});
        check("x79_off",    {20'd0, line_rgb[79]}, {20'd0, C_OFF});

        // last word of the screen, word 8191 = 16'h8000
        clear_line();
        for (int x = 544; x <= 580; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd367, 1'b1);
        idle(4);
        check("addr_max",    {19'd0, last_addr}, 32'd8191);
        check("x560_off",    {20'd0, line_rgb[560]}, {20'd0, C_OFF});
        check("x574_off",    {20'd0, line_rgb[574]}, {20'd0, C_OFF});
        check("x575_on",     {20'd0, line_rgb[575]}, {20'd0, C_ON});
        check("x576_border", {20'd0, line_rgb[576]}, {20'd0, C_BORDER});

        // blanking inside the window, and video_on dropping mid-word
        clear_line();
        for (int x = 64; x <= 70; x++) drive(1'b1, 1'b1, 1'b1, 1'b0, 10'(x), 10'd112, 1'b1);
        idle(4);
        check("blank_x64", {20'd0, line_rgb[64]}, 32'd0);
        clear_line();
        for (int x = 64; x <= 69; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd112, 1'b1);
        for (int x = 70; x <= 73; x++) drive(1'b1, 1'b1, 1'b1, 1'b0, 10'(x), 10'd112, 1'b1);
        idle(4);
        check("drop_x64", {20'd0, line_rgb[64]}, {20'd0, C_ON});
        check("drop_x70", {20'd0, line_rgb[70]}, 32'd0);

        // partial frame sweep: full 800-pixel lines around the window edges
        begin
            int ys [10] = '{0, 111, 112, 113, 250, 367, 368, 479, 480, 490};
            foreach (ys[k]) begin
                rd_cnt = 0;
                for (int x = 0; x < 800; x++)
                    drive(1'b1, !(x >= 656 && x < 752), !(ys[k] >= 490 && ys[k] < 492),
                          (x < 640) && (ys[k] < 480), 10'(x), 10'(ys[k]), 1'b1);
                check("reads_per_line", 32'(rd_cnt), (ys[k] >= 112 && ys[k] < 368) ? 32'd32 : 32'd0);
            end
        end

        // reset in the middle of a Hack line
        clear_line();
        for (int x = 0; x < 100; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd113, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd100, 10'd113, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd101, 10'd113, 1'b1);
        for (int x = 102; x < 112; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd113, 1'b0);
        for (int x = 112; x < 200; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, 10'(x), 10'd113, 1'b1);
        idle(4);
        check("rst_x112_on",  {20'd0, line_rgb[112]}, {20'd0, C_ON});
        check("rst_x113_on",  {20'd0, line_rgb[113]}, {20'd0, C_ON});
        check("rst_x116_off", {20'd0, line_rgb[116]}, {20'd0, C_OFF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_vga_pixel.md
# hack_vga_pixel

Pixel generation stage directly downstream of the VGA sync generator. It takes the sync generator's hsync/vsync/video_on and x/y coordinates, fetches 16-bit words from the Hack screen RAM (512x256 monochrome, 32 words per row), and serializes them into 12-bit RGB. It delays the sync signals to match the fetch pipeline. It places the 512x256 Hack screen inside the 640x480 active area, with a border colour around it.

## Interface
- X_OFF, 64: left edge of the Hack window in display pixels; must be a multiple of 16.
- Y_OFF, 112: top row of the Hack window in display lines.
- PIX_ON, 12'h000: RGB for a screen bit of 1.
- PIX_OFF, 12'hFFF: RGB for a screen bit of 0.
- BORDER, 12'h222: RGB inside video_on but outside the Hack window.
- pixel_clk  in  1  pixel clock; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_hsync  in  1  hsync from sync stage.
- in_vsync  in  1  vsync from sync stage.
- in_video_on  in  1  active-area flag from sync stage.
- x_addr  in  10  display x coordinate; valid when in_video_on=1.
- y_addr  in  10  display y coordinate; valid when in_video_on=1.
- ram_addr  out  13  screen RAM word address (row*32 + col).
- ram_rd  out  1  read strobe, one cycle per fetched word.
- ram_rdata  in  16  screen RAM data, returned exactly 1 cycle after ram_addr/ram_rd.
- vga_hsync  out  1  hsync delayed by 3 cycles.
- vga_vsync  out  1  vsync delayed by 3 cycles.
- vga_r / vga_g / vga_b  out  4 each  pixel colour.

## Operation
- Window test (stage 0, combinational on inputs):
  - in_win = in_video_on && X_OFF <= x_addr < X_OFF+512 && Y_OFF <= y_addr < Y_OFF+256.
  - hx = x_addr - X_OFF (9 bits used); hy = y_addr - Y_OFF (8 bits used).
- Fetch (stage 1, registered):
  - When in_win && hx[3:0]==0: ram_addr <= {hy[7:0], hx[8:4]} and ram_rd <= 1.
  - Otherwise ram_rd <= 0 and ram_addr holds its value.
- Data (stage 2):
  - ram_rdata arrives for the word started in stage 1.
  - Bit order: bit 0 is the leftmost pixel of the word (Hack convention).
  - On a word-start pixel, the pixel value is ram_rdata[0] and shift_reg <= ram_rdata >> 1.
  - On any other in-window pixel, the pixel value is shift_reg[0] and shift_reg <= shift_reg >> 1.
- Colour select (stage 3, registered outputs):
  - video_on delayed = 0 → RGB 0.
  - Delayed in_win = 0 → BORDER.
  - Otherwise the pixel value selects PIX_ON or PIX_OFF.
- Pipeline flags: video_on, in_win, word-start and hsync/vsync are each carried through a 3-deep register pipe alongside the data.
- No handshake or backpressure exists; the RAM must return data every fetch with fixed 1-cycle latency.

## Timing
- Latency: the input sample at cycle t appears on RGB and on vga_hsync/vga_vsync at cycle t+3; syncs and colour stay mutually aligned.
- ram_rd fires at t+1 for every input pixel at a word start. This gives 32 reads per Hack line, every 16th cycle, and 256 lines per frame.
- Reset (reset_n=0, asynchronous) clears to 0:
  - all pipeline registers, shift_reg, ram_addr, ram_rd;
  - vga_hsync, vga_vsync, RGB.
- Reset release: outputs are valid 3 cycles after the first valid input sample.
- Reset mid-line: all outputs go to 0 immediately. The first word is re-fetched at the next word-start pixel; no stale shift data is ever displayed because each word start reloads from ram_rdata.
- Window edges:
  - x = X_OFF+511 is the last shifted pixel (bit 15); x = X_OFF+512 shows BORDER.
  - y = Y_OFF+255 → address 8160..8191; y = Y_OFF+256 issues no reads.
- Address arithmetic wraps at 13 bits. Maximum address is 8191, reached at hy=255, hx=496..511.
- When in_video_on drops mid-word, the remaining shift bits are discarded; output is 0.

## Test plan
- Reset: hold reset_n=0 with random inputs → RGB=0, syncs=0, ram_rd=0; release, then drive x=0,y=0,video_on=1 → RGB=BORDER at t+3.
- Word fetch: x=64,y=112 → ram_addr=0, ram_rd=1 at t+1. Return 16'h0001 → pixel x=64 is PIX_ON and x=65..79 are PIX_OFF at t+3..t+18.
- Address map: x=64+496, y=112+255 → ram_addr=8191. Return 16'h8000 → only the final pixel (x=575) is PIX_ON.
- Full frame: 800x525 sweep with RAM model data = address → exactly 8192 ram_rd pulses per frame; every RGB matches the model; syncs equal the inputs delayed by 3.
- Border and blank: x=63 → BORDER; x=576 → BORDER; video_on=0 → RGB 0 regardless of ram_rdata.
- Mid-line reset: assert reset_n=0 at x=100 for 2 cycles → RGB=0 immediately. The next word start at x=112 reloads from ram_rdata and the output is correct from t+3.
